// File: rtl/cci_rd_arbiter_if.sv
// Bus bundle between the two fetch engines, the read arbiter and the CCI read channel.
// The slave modport is the arbiter's view; master is the environment driving it.
interface cci_rd_arbiter_if #(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512
);
    logic [ADDR_LMT-1:0]    rq0_addr;
    logic [ADDR_LMT-1:0]    rq1_addr;
    logic [MDATA-2:0]       rq0_mdata;
    logic [MDATA-2:0]       rq1_mdata;
    logic                   rq0_en;
    logic                   rq1_en;
    logic                   rq0_almostfull;
    logic                   rq1_almostfull;

    logic [ADDR_LMT-1:0]    rd_req_addr;
    logic [MDATA-1:0]       rd_req_mdata;
    logic                   rd_req_en;
    logic                   rd_req_almostfull;

    logic                   rd_rsp_valid;
    logic [MDATA-1:0]       rd_rsp_mdata;
    logic [CACHE_WIDTH-1:0] rd_rsp_data;

    logic                   rsp0_valid;
    logic                   rsp1_valid;
    logic [MDATA-2:0]       rsp0_mdata;
    logic [MDATA-2:0]       rsp1_mdata;
    logic [CACHE_WIDTH-1:0] rsp0_data;
    logic [CACHE_WIDTH-1:0] rsp1_data;

    modport slave (
        input  rq0_addr, rq1_addr, rq0_mdata, rq1_mdata, rq0_en, rq1_en,
        input  rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
        output rq0_almostfull, rq1_almostfull,
        output rd_req_addr, rd_req_mdata, rd_req_en,
        output rsp0_valid, rsp1_valid, rsp0_mdata, rsp1_mdata, rsp0_data, rsp1_data
    );

    modport master (
        output rq0_addr, rq1_addr, rq0_mdata, rq1_mdata, rq0_en, rq1_en,
        output rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
        input  rq0_almostfull, rq1_almostfull,
        input  rd_req_addr, rd_req_mdata, rd_req_en,
        input  rsp0_valid, rsp1_valid, rsp0_mdata, rsp1_mdata, rsp0_data, rsp1_data
    );
endinterface

// File: rtl/cci_rd_arbiter.sv
// Two-requester round-robin arbiter for the CCI read port: per-requester request
// FIFOs, in-flight credit limits, and tag-based routing of read responses.
module cci_rd_arbiter #(
    parameter int ADDR_LMT        = 20,
    parameter int MDATA           = 14,
    parameter int CACHE_WIDTH     = 512,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic              clk,
    input  logic              rst,
    cci_rd_arbiter_if.slave   bus,
    output logic              idle,
    output logic              err
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int MW   = MDATA - 1;

    logic [ADDR_LMT-1:0]    rq_addr [2];
    logic [MW-1:0]          rq_mdata [2];
    logic [1:0]             rq_en;
    logic [1:0]             rq_af;

    logic [ADDR_LMT-1:0]    mem_addr_q [2][FIFO_DEPTH];
    logic [MW-1:0]          mem_mdata_q [2][FIFO_DEPTH];
    logic [ADDR_LMT-1:0]    head_addr [2];
    logic [MW-1:0]          head_mdata [2];

    logic [PW-1:0]          wr_ptr_q [2], wr_ptr_d [2];
    logic [PW-1:0]          rd_ptr_q [2], rd_ptr_d [2];
    logic [CNTW-1:0]        cnt_q [2], cnt_d [2];
    logic [CW-1:0]          outst_q [2], outst_d [2];

    logic [1:0]             push, ovf, elig, grant, rsp_hit, unmatched;
    logic                   gsel;
    logic                   rr_q, rr_d;

    logic                   rd_req_en_q, rd_req_en_d;
    logic [ADDR_LMT-1:0]    rd_req_addr_q, rd_req_addr_d;
    logic [MDATA-1:0]       rd_req_mdata_q, rd_req_mdata_d;
    logic [1:0]             rsp_valid_q, rsp_valid_d;
    logic [MW-1:0]          rsp_mdata_q [2], rsp_mdata_d [2];
    logic [CACHE_WIDTH-1:0] rsp_data_q [2], rsp_data_d [2];
    logic                   idle_q, idle_d;
    logic                   err_q, err_d;

    assign rq_addr[0]  = bus.rq0_addr;
    assign rq_addr[1]  = bus.rq1_addr;
    assign rq_mdata[0] = bus.rq0_mdata;
    assign rq_mdata[1] = bus.rq1_mdata;
    assign rq_en       = {bus.rq1_en, bus.rq0_en};

    assign bus.rq0_almostfull = rq_af[0];
    assign bus.rq1_almostfull = rq_af[1];
    assign bus.rd_req_en      = rd_req_en_q;
    assign bus.rd_req_addr    = rd_req_addr_q;
    assign bus.rd_req_mdata   = rd_req_mdata_q;
    assign bus.rsp0_valid     = rsp_valid_q[0];
    assign bus.rsp1_valid     = rsp_valid_q[1];
    assign bus.rsp0_mdata     = rsp_mdata_q[0];
    assign bus.rsp1_mdata     = rsp_mdata_q[1];
    assign bus.rsp0_data      = rsp_data_q[0];
    assign bus.rsp1_data      = rsp_data_q[1];
    assign idle               = idle_q;
    assign err                = err_q;

    // Per-requester status; the head is read from registered state only, so a
    // freshly pushed entry cannot be granted in the same cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            push[i]       = rq_en[i] && (cnt_q[i] != CNTW'(FIFO_DEPTH));
            ovf[i]        = rq_en[i] && (cnt_q[i] == CNTW'(FIFO_DEPTH));
            rq_af[i]      = cnt_q[i] >= CNTW'(FIFO_DEPTH - 2);
            elig[i]       = (cnt_q[i] != '0) && (outst_q[i] < CW'(MAX_OUTSTANDING))
                            && !bus.rd_req_almostfull;
            rsp_hit[i]    = bus.rd_rsp_valid && (bus.rd_rsp_mdata[MDATA-1] == 1'(i));
            unmatched[i]  = rsp_hit[i] && (outst_q[i] == '0);
            head_addr[i]  = mem_addr_q[i][rd_ptr_q[i]];
            head_mdata[i] = mem_mdata_q[i][rd_ptr_q[i]];
        end
    end

    // rr_q holds the last granted requester; on contention the other one wins.
    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = rr_q ? 2'b01 : 2'b10;
        end
        gsel = grant[1];
        rr_d = (grant != 2'b00) ? gsel : rr_q;
    end

    always_comb begin
        rd_req_en_d    = |grant;
        rd_req_addr_d  = rd_req_addr_q;
        rd_req_mdata_d = rd_req_mdata_q;
        if (|grant) begin
            rd_req_addr_d  = head_addr[gsel];
            rd_req_mdata_d = {gsel, head_mdata[gsel]};
        end
        idle_d = 1'b1;
        err_d  = err_q || (|ovf) || (|unmatched);
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PW'(grant[i]);
            cnt_d[i]    = cnt_q[i] + CNTW'(push[i]) - CNTW'(grant[i]);
            outst_d[i]  = outst_q[i];
            if (grant[i] && !rsp_hit[i]) begin
                outst_d[i] = outst_q[i] + CW'(1);
            end else if (!grant[i] && rsp_hit[i] && (outst_q[i] != '0)) begin
                outst_d[i] = outst_q[i] - CW'(1);
            end
            rsp_valid_d[i] = rsp_hit[i];
            rsp_mdata_d[i] = rsp_hit[i] ? bus.rd_rsp_mdata[MW-1:0] : rsp_mdata_q[i];
            rsp_data_d[i]  = rsp_hit[i] ? bus.rd_rsp_data : rsp_data_q[i];
            if ((cnt_d[i] != '0) || (outst_d[i] != '0)) begin
                idle_d = 1'b0;
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_addr_q[i][wr_ptr_q[i]]  <= rq_addr[i];
                mem_mdata_q[i][wr_ptr_q[i]] <= rq_mdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q           <= 1'b1;
            rd_req_en_q    <= 1'b0;
            rd_req_addr_q  <= '0;
            rd_req_mdata_q <= '0;
            rsp_valid_q    <= '0;
            idle_q         <= 1'b1;
            err_q          <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i]    <= '0;
                rd_ptr_q[i]    <= '0;
                cnt_q[i]       <= '0;
                outst_q[i]     <= '0;
                rsp_mdata_q[i] <= '0;
                rsp_data_q[i]  <= '0;
            end
        end else begin
            rr_q           <= rr_d;
            rd_req_en_q    <= rd_req_en_d;
            rd_req_addr_q  <= rd_req_addr_d;
            rd_req_mdata_q <= rd_req_mdata_d;
            rsp_valid_q    <= rsp_valid_d;
            idle_q         <= idle_d;
            err_q          <= err_d;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i]    <= wr_ptr_d[i];
                rd_ptr_q[i]    <= rd_ptr_d[i];
                cnt_q[i]       <= cnt_d[i];
                outst_q[i]     <= outst_d[i];
                rsp_mdata_q[i] <= rsp_mdata_d[i];
                rsp_data_q[i]  <= rsp_data_d[i];
            end
        end
    end
endmodule

// File: tb/tb_cci_rd_arbiter.sv
// Directed bench for cci_rd_arbiter: a per-cycle vector table for single-request
// and contention traffic, then hand-written multi-cycle corner-case sequences.
module tb_cci_rd_arbiter;
    localparam int AL  = 20;
    localparam int MD  = 14;
    localparam int CWD = 512;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic idle, err;

    cci_rd_arbiter_if #(.ADDR_LMT(AL), .MDATA(MD), .CACHE_WIDTH(CWD)) bus ();

    cci_rd_arbiter #(
        .ADDR_LMT(AL), .MDATA(MD), .CACHE_WIDTH(CWD), .FIFO_DEPTH(4), .MAX_OUTSTANDING(32)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .idle (idle),
        .err  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          e0;
        logic [AL-1:0] a0;
        logic [MD-2:0] m0;
        logic          e1;
        logic [AL-1:0] a1;
        logic [MD-2:0] m1;
        logic          raf;
        logic          rv;
        logic [MD-1:0] rm;
        logic          x_en;
        logic [AL-1:0] x_addr;
        logic [MD-1:0] x_md;
        logic          x_af0, x_af1, x_v0, x_v1, x_idle, x_err;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   iss0 = 0;
    int   iss1 = 0;

    function automatic logic [CWD-1:0] pat(input logic [MD-1:0] m);
        return {32{m, 2'b10}};
    endfunction

    function automatic void add(
        input logic r, input logic e0, input logic [AL-1:0] a0, input logic [MD-2:0] m0,
        input logic e1, input logic [AL-1:0] a1, input logic [MD-2:0] m1,
        input logic raf, input logic rv, input logic [MD-1:0] rm,
        input logic xe, input logic [AL-1:0] xa, input logic [MD-1:0] xm,
        input logic xf0, input logic xf1, input logic xv0, input logic xv1,
        input logic xi, input logic xr);
        vec_t v;
        v.rst_n = r;  v.e0 = e0; v.a0 = a0; v.m0 = m0; v.e1 = e1; v.a1 = a1; v.m1 = m1;
        v.raf = raf; v.rv = rv; v.rm = rm;
        v.x_en = xe; v.x_addr = xa; v.x_md = xm; v.x_af0 = xf0; v.x_af1 = xf1;
        v.x_v0 = xv0; v.x_v1 = xv1; v.x_idle = xi; v.x_err = xr;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkd(input string nm, input logic [CWD-1:0] act, input logic [CWD-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act[63:0], exp[63:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.rd_req_en === 1'b1) begin
            if (bus.rd_req_mdata[MD-1]) iss1++;
            else                        iss0++;
        end
    endtask

    task automatic clr_inputs();
        bus.rq0_en = 1'b0; bus.rq0_addr = '0; bus.rq0_mdata = '0;
        bus.rq1_en = 1'b0; bus.rq1_addr = '0; bus.rq1_mdata = '0;
        bus.rd_req_almostfull = 1'b0;
        bus.rd_rsp_valid = 1'b0; bus.rd_rsp_mdata = '0; bus.rd_rsp_data = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        iss0 = 0;
        iss1 = 0;
    endtask

    task automatic rsp(input logic [MD-1:0] m);
        bus.rd_rsp_valid = 1'b1;
        bus.rd_rsp_mdata = m;
        bus.rd_rsp_data  = pat(m);
        tick();
        bus.rd_rsp_valid = 1'b0;
    endtask

    initial begin
        logic seen;
        clr_inputs();

        // single request, then 3+3 contention from reset, then drain
        add(0, 0,'h0,0,     0,'h0,0,     0, 0,'h0,    0,'h0,'h0,      0,0,0,0,1,0);
        add(1, 1,'h10,5,    0,'h0,0,     0, 0,'h0,    0,'h0,'h0,      0,0,0,0,0,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 0,'h0,    1,'h10,'h0005,  0,0,0,0,0,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 1,'h0005, 0,'h10,'h0005,  0,0,1,0,1,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 0,'h0,    0,'h10,'h0005,  0,0,0,0,1,0);
        add(0, 0,'h0,0,     0,'h0,0,     0, 0,'h0,    0,'h0,'h0,      0,0,0,0,1,0);
        add(1, 1,'h100,1,   1,'h200,2,   0, 0,'h0,    0,'h0,'h0,      0,0,0,0,0,0);
        add(1, 1,'h101,3,   1,'h201,4,   0, 0,'h0,    1,'h100,'h0001, 0,1,0,0,0,0);
        add(1, 1,'h102,5,   1,'h202,6,   0, 0,'h0,    1,'h200,'h2002, 1,1,0,0,0,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 0,'h0,    1,'h101,'h0003, 0,1,0,0,0,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 0,'h0,    1,'h201,'h2004, 0,0,0,0,0,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 0,'h0,    1,'h102,'h0005, 0,0,0,0,0,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 0,'h0,    1,'h202,'h2006, 0,0,0,0,0,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 0,'h0,    0,'h202,'h2006, 0,0,0,0,0,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 1,'h0001, 0,'h202,'h2006, 0,0,1,0,0,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 1,'h2002, 0,'h202,'h2006, 0,0,0,1,0,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 1,'h0003, 0,'h202,'h2006, 0,0,1,0,0,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 1,'h2004, 0,'h202,'h2006, 0,0,0,1,0,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 1,'h0005, 0,'h202,'h2006, 0,0,1,0,0,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 1,'h2006, 0,'h202,'h2006, 0,0,0,1,1,0);
        add(1, 0,'h0,0,     0,'h0,0,     0, 0,'h0,    0,'h202,'h2006, 0,0,0,0,1,0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst_n;
            bus.rq0_en = vecs[i].e0; bus.rq0_addr = vecs[i].a0; bus.rq0_mdata = vecs[i].m0;
            bus.rq1_en = vecs[i].e1; bus.rq1_addr = vecs[i].a1; bus.rq1_mdata = vecs[i].m1;
            bus.rd_req_almostfull = vecs[i].raf;
            bus.rd_rsp_valid = vecs[i].rv; bus.rd_rsp_mdata = vecs[i].rm;
            bus.rd_rsp_data  = pat(vecs[i].rm);
            tick();
            $display("vec %0d: en=%0b addr=%0h mdata=%0h v0=%0b v1=%0b idle=%0b err=%0b",
                     i, bus.rd_req_en, bus.rd_req_addr, bus.rd_req_mdata,
                     bus.rsp0_valid, bus.rsp1_valid, idle, err);
            chk($sformatf("v%0d_en", i),    64'(bus.rd_req_en),      64'(vecs[i].x_en));
            chk($sformatf("v%0d_addr", i),  64'(bus.rd_req_addr),    64'(vecs[i].x_addr));
            chk($sformatf("v%0d_mdata", i), 64'(bus.rd_req_mdata),   64'(vecs[i].x_md));
            chk($sformatf("v%0d_af0", i),   64'(bus.rq0_almostfull), 64'(vecs[i].x_af0));
            chk($sformatf("v%0d_af1", i),   64'(bus.rq1_almostfull), 64'(vecs[i].x_af1));
            chk($sformatf("v%0d_v0", i),    64'(bus.rsp0_valid),     64'(vecs[i].x_v0));
            chk($sformatf("v%0d_v1", i),    64'(bus.rsp1_valid),     64'(vecs[i].x_v1));
            chk($sformatf("v%0d_idle", i),  64'(idle),               64'(vecs[i].x_idle));
            chk($sformatf("v%0d_err", i),   64'(err),                64'(vecs[i].x_err));
            if (vecs[i].x_v0) begin
                chk($sformatf("v%0d_rsp0_md", i), 64'(bus.rsp0_mdata), 64'(vecs[i].rm[MD-2:0]));
                chkd($sformatf("v%0d_rsp0_data", i), bus.rsp0_data, pat(vecs[i].rm));
            end
            if (vecs[i].x_v1) begin
                chk($sformatf("v%0d_rsp1_md", i), 64'(bus.rsp1_mdata), 64'(vecs[i].rm[MD-2:0]));
                chkd($sformatf("v%0d_rsp1_data", i), bus.rsp1_data, pat(vecs[i].rm));
            end
        end
        clr_inputs();

        // backpressure: 10 cycles blocked with both FIFOs at occupancy 2
        do_reset();
        bus.rd_req_almostfull = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.rq0_en = 1'b1; bus.rq0_addr = AL'('h300 + k); bus.rq0_mdata = (MD-1)'(k);
            bus.rq1_en = 1'b1; bus.rq1_addr = AL'('h400 + k); bus.rq1_mdata = (MD-1)'(k);
            tick();
            chk("bp_en_load", 64'(bus.rd_req_en), 64'(0));
            chk("bp_af0_load", 64'(bus.rq0_almostfull), 64'(k == 1));
        end
        bus.rq0_en = 1'b0; bus.rq1_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("bp_en_hold", 64'(bus.rd_req_en), 64'(0));
        end
        chk("bp_af0", 64'(bus.rq0_almostfull), 64'(1));
        chk("bp_af1", 64'(bus.rq1_almostfull), 64'(1));
        bus.rd_req_almostfull = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            $display("bp issue %0d: en=%0b addr=%0h", k, bus.rd_req_en, bus.rd_req_addr);
            chk("bp_resume_en", 64'(bus.rd_req_en), 64'(1));
            chk("bp_resume_addr", 64'(bus.rd_req_addr),
                64'((k % 2 == 0) ? ('h300 + k / 2) : ('h400 + k / 2)));
        end

        // credit limit on requester 1
        do_reset();
        for (int k = 0; k < 33; k++) begin
            bus.rq1_en = 1'b1; bus.rq1_addr = AL'(k); bus.rq1_mdata = (MD-1)'(k);
            tick();
        end
        bus.rq1_en = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        $display("credit: iss1=%0d en=%0b idle=%0b", iss1, bus.rd_req_en, idle);
        chk("credit_iss1", 64'(iss1), 64'(32));
        chk("credit_held_en", 64'(bus.rd_req_en), 64'(0));
        chk("credit_idle", 64'(idle), 64'(0));
        for (int k = 0; k < 2; k++) begin
            bus.rq0_en = 1'b1; bus.rq0_addr = AL'('h500 + k); bus.rq0_mdata = (MD-1)'(k);
            tick();
        end
        bus.rq0_en = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("credit_rq0_iss", 64'(iss0), 64'(2));
        chk("credit_rq1_still", 64'(iss1), 64'(32));
        rsp(14'h2000);
        chk("credit_rsp1_v", 64'(bus.rsp1_valid), 64'(1));
        chk("credit_rsp0_v", 64'(bus.rsp0_valid), 64'(0));
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            tick();
            if (bus.rd_req_en === 1'b1 && bus.rd_req_mdata[MD-1] === 1'b1) seen = 1'b1;
        end
        $display("credit resume: seen=%0b iss1=%0d addr=%0h", seen, iss1, bus.rd_req_addr);
        chk("credit_resume", 64'(seen), 64'(1));
        chk("credit_resume_addr", 64'(bus.rd_req_addr), 64'(32));

        // overflow and unmatched response
        do_reset();
        bus.rd_req_almostfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.rq0_en = 1'b1; bus.rq0_addr = AL'('h600 + k); bus.rq0_mdata = (MD-1)'(k);
            tick();
            if (k == 3) chk("err_before_ovf", 64'(err), 64'(0));
        end
        bus.rq0_en = 1'b0;
        $display("overflow: err=%0b af0=%0b", err, bus.rq0_almostfull);
        chk("err_ovf", 64'(err), 64'(1));
        chk("err_ovf_af0", 64'(bus.rq0_almostfull), 64'(1));
        do_reset();
        chk("err_cleared", 64'(err), 64'(0));
        rsp(14'h2007);
        $display("unmatched: v1=%0b md=%0h err=%0b idle=%0b", bus.rsp1_valid, bus.rsp1_mdata, err, idle);
        chk("unm_v1", 64'(bus.rsp1_valid), 64'(1));
        chk("unm_v0", 64'(bus.rsp0_valid), 64'(0));
        chk("unm_md", 64'(bus.rsp1_mdata), 64'(7));
        chk("unm_err", 64'(err), 64'(1));
        chk("unm_idle", 64'(idle), 64'(1));
        tick();
        chk("unm_err_sticky", 64'(err), 64'(1));

        // reset with 4 outstanding and 3 queued
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.rq0_en = 1'b1; bus.rq0_addr = AL'('h700 + k); bus.rq0_mdata = (MD-1)'(k);
            tick();
        end
        bus.rq0_en = 1'b0;
        tick();
        chk("mid_iss0", 64'(iss0), 64'(4));
        bus.rd_req_almostfull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.rq1_en = 1'b1; bus.rq1_addr = AL'('h800 + k); bus.rq1_mdata = (MD-1)'(k);
            tick();
        end
        bus.rq1_en = 1'b0;
        chk("mid_busy", 64'(idle), 64'(0));
        chk("mid_af1", 64'(bus.rq1_almostfull), 64'(1));
        #2 rst = 1'b0;
        #1;
        $display("mid reset: en=%0b addr=%0h md=%0h idle=%0b err=%0b",
                 bus.rd_req_en, bus.rd_req_addr, bus.rd_req_mdata, idle, err);
        chk("rst_en", 64'(bus.rd_req_en), 64'(0));
        chk("rst_addr", 64'(bus.rd_req_addr), 64'(0));
        chk("rst_md", 64'(bus.rd_req_mdata), 64'(0));
        chk("rst_idle", 64'(idle), 64'(1));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_af1", 64'(bus.rq1_almostfull), 64'(0));
        chk("rst_v0", 64'(bus.rsp0_valid), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        bus.rd_req_almostfull = 1'b0;
        iss0 = 0; iss1 = 0;
        for (int k = 0; k < 4; k++) tick();
        chk("rst_flushed", 64'(iss0 + iss1), 64'(0));
        chk("rst_idle_after", 64'(idle), 64'(1));
        rsp(14'h0702);
        $display("straggler: v0=%0b md=%0h err=%0b idle=%0b", bus.rsp0_valid, bus.rsp0_mdata, err, idle);
        chk("strag_v0", 64'(bus.rsp0_valid), 64'(1));
        chk("strag_md", 64'(bus.rsp0_mdata), 64'('h702));
        chk("strag_err", 64'(err), 64'(1));
        chk("strag_idle", 64'(idle), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
